// File: rtl/template_match_scheduler_pkg.sv
// Shared constants and FSM state encoding for the template match scheduler.
package template_match_scheduler_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned N_DIGIT = 10;
  localparam int unsigned PIX_CNT = 4096;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_SELECT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/match_argmax.sv
// Sequential argmax over the per-digit match counters, one counter per step.
module match_argmax #(
  parameter int unsigned N_DIGIT = 10,
  parameter int unsigned CNT_W   = 13,
  parameter int unsigned IDX_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              step,
  input  logic [N_DIGIT-1:0][CNT_W-1:0]     cnt,
  output logic [IDX_W-1:0]                  best_idx_c,
  output logic [CNT_W-1:0]                  best_val_c,
  output logic                              last_c
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [CNT_W-1:0] best_val_q;
  logic [CNT_W-1:0] cur_c;
  logic             take_c;

  // Index 0 always loads; later entries replace only when strictly greater.
  always_comb begin
    cur_c      = cnt[idx_q];
    take_c     = (idx_q == '0) || (cur_c > best_val_q);
    best_val_c = take_c ? cur_c : best_val_q;
    best_idx_c = take_c ? idx_q : best_idx_q;
    last_c     = (idx_q == IDX_W'(N_DIGIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (step) begin
      idx_q      <= idx_q + IDX_W'(1);
      best_idx_q <= best_idx_c;
      best_val_q <= best_val_c;
    end else begin
      idx_q <= '0;
    end
  end

endmodule

// File: rtl/template_match_scheduler.sv
// Scans all template ROMs against the binarized image in parallel and reports
// the digit whose template matches the most pixels.
module template_match_scheduler #(
  parameter int unsigned ADDR_W  = template_match_scheduler_pkg::ADDR_W,
  parameter int unsigned N_DIGIT = template_match_scheduler_pkg::N_DIGIT,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              abort,
  output logic                                              busy,
  output logic                                              done,
  output logic [ADDR_W-1:0]                                 rom_ad,
  output logic                                              rom_ce,
  input  logic [N_DIGIT-1:0]                                tpl_bit,
  output logic [ADDR_W-1:0]                                 img_ad,
  output logic                                              img_rd_en,
  input  logic                                              img_bit,
  output logic [template_match_scheduler_pkg::DIGIT_W-1:0]  digit,
  output logic [ADDR_W:0]                                   score
);

  import template_match_scheduler_pkg::*;

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q;
  logic [DRAIN_W-1:0]             drain_q;
  logic [RD_LAT-1:0]              vld_q;
  logic [N_DIGIT-1:0][CNT_W-1:0]  cnt_q;
  logic                           scan_q;
  logic                           busy_d, scan_d, done_d;
  logic [DIGIT_W-1:0]             best_idx_c;
  logic [CNT_W-1:0]               best_val_c;
  logic                           last_c;

  assign rom_ad    = addr_q;
  assign img_ad    = addr_q;
  assign rom_ce    = scan_q;
  assign img_rd_en = scan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    scan_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SCAN;
      ST_SCAN:   if (&addr_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q == DRAIN_W'(RD_LAT - 1)) state_d = ST_SELECT;
      ST_SELECT: if (last_c) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    busy_d = (state_d != ST_IDLE);
    scan_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      scan_q <= 1'b0;
      digit  <= '0;
      score  <= '0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      scan_q <= scan_d;
      if (done_d) begin
        digit <= best_idx_c;
        score <= best_val_c;
      end
    end
  end

  // Address counter restarts at 0 on entry to SCAN and stops at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      if (state_d == ST_SCAN)
        addr_q <= (state_q == ST_SCAN) ? addr_q + ADDR_W'(1) : '0;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  // Valid line tags the cycles on which ROM/image data is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               vld_q <= '0;
    else if (abort && (state_q != ST_IDLE))   vld_q <= '0;
    else                                      vld_q <= RD_LAT'({vld_q, scan_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      cnt_q <= '0;
    end else if (vld_q[RD_LAT-1]) begin
      for (int unsigned d = 0; d < N_DIGIT; d++)
        if (tpl_bit[d] == img_bit) cnt_q[d] <= cnt_q[d] + CNT_W'(1);
    end
  end

  match_argmax #(
    .N_DIGIT (N_DIGIT),
    .CNT_W   (CNT_W),
    .IDX_W   (DIGIT_W)
  ) u_argmax (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (state_q == ST_SELECT),
    .cnt        (cnt_q),
    .best_idx_c (best_idx_c),
    .best_val_c (best_val_c),
    .last_c     (last_c)
  );

endmodule

// File: doc/template_match_scheduler.md
TEMPLATE_MATCH_SCHEDULER -- requirements
Module: template_match_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning template/image address width (64x64 = 4096 pixels).
REQ-002 SHALL have parameter N_DIGIT, default 10, meaning number of 1-bit template ROMs scanned in parallel.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning clock cycles from address to data for ROMs and image memory.
REQ-004 SHALL have ports: clk  in  1  single system clock (all logic rising-edge).
REQ-005 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  one-cycle request to begin a match pass.
REQ-007 SHALL have ports: abort  in  1  cancel the current pass.
REQ-008 SHALL have ports: busy  out  1  pass in progress.
REQ-009 SHALL have ports: done  out  1  one-cycle pulse when results are updated.
REQ-010 SHALL have ports: rom_ad  out  ADDR_W  shared address to all template ROMs.
REQ-011 SHALL have ports: rom_ce  out  1  template ROM clock enable.
REQ-012 SHALL have ports: tpl_bit  in  N_DIGIT  bit d = dout of template ROM for digit d.
REQ-013 SHALL have ports: img_ad  out  ADDR_W  binarized-image memory address.
REQ-014 SHALL have ports: img_rd_en  out  1  image read enable.
REQ-015 SHALL have ports: img_bit  in  1  binarized pixel (1 = background, 0 = ink).
REQ-016 SHALL have ports: digit  out  4  recognised digit; score  out  ADDR_W+1  its match count.

Function
REQ-017 SHALL implement FSM IDLE -> SCAN -> DRAIN -> SELECT -> DONE -> IDLE.
REQ-018 IDLE: start=1 SHALL enter SCAN next cycle, clear all N_DIGIT counters, and set the address counter to 0.
REQ-019 SCAN: rom_ad = img_ad = address counter; rom_ce = img_rd_en = 1; the counter SHALL increment by 1 per cycle for exactly 2^ADDR_W cycles (0..4095), with no wrap back to 0 inside a pass.
REQ-020 A valid shift line of depth RD_LAT SHALL tag returned data; on each tagged cycle, counter[d] SHALL increment iff tpl_bit[d] == img_bit.
REQ-021 Counters SHALL be ADDR_W+1 bits wide (max 4096), with no saturation logic needed.
REQ-022 DRAIN SHALL last exactly RD_LAT cycles with rom_ce = img_rd_en = 0, then enter SELECT.
REQ-023 SELECT SHALL compare counters sequentially, one per cycle, for N_DIGIT cycles in order 0..9.
REQ-024 SELECT: the best candidate SHALL be replaced only if strictly greater, so ties resolve to the lowest digit.
REQ-025 DONE SHALL last one cycle: digit/score update, done=1, then return to IDLE.
REQ-026 Latency: with start sampled at cycle 0, done SHALL be high at cycle 2^ADDR_W + RD_LAT + N_DIGIT + 1 (4108 at defaults).
REQ-027 busy SHALL be 1 in SCAN, DRAIN, SELECT and DONE, and 0 in IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no done pulse and digit/score unchanged.
REQ-030 abort and start high together in IDLE: start SHALL win.
REQ-031 digit/score SHALL hold their values between passes.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state=IDLE, busy=0, done=0, rom_ce=0, img_rd_en=0, rom_ad=0, img_ad=0, digit=0, score=0, all counters and the valid line=0.
REQ-033 Reset deassertion mid-pass SHALL leave the block in IDLE awaiting a new start.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, ADDR_W, N_DIGIT, PIX_CNT=4096 and the DIGIT_W=4 constants.
REQ-035 A single sub-module, match_argmax, SHALL hold the sequential max search (counter index, best value, best index).
REQ-036 Template ROM outputs SHALL be concatenated into tpl_bit at top level.
REQ-037 ROM oce SHALL be tied 1 and ROM reset tied 0 at top level, not driven by this block.

Verification
REQ-038 Image all-1, template 5 all-1, other templates all-0 -> done at cycle 4108, digit=5, score=4096.
REQ-039 Image equals template 3, all templates distinct -> digit=3, score=4096.
REQ-040 Templates 2 and 7 both give 4000 matches, all others fewer -> digit=2, score=4000.
REQ-041 abort at cycle 2000 of SCAN -> busy=0 next cycle, no done, previous digit/score retained; a new start then completes normally.
REQ-042 start pulses during SCAN -> ignored, with exactly one done per accepted start.
REQ-043 rst_n low at cycle 3000 -> all outputs at reset values immediately, and rom_ce=0.
